// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux_pkg
//  Description : Shared constants and helpers for the stream_demux block:
//                mode encoding, default geometry, pointer wrap-increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

  // Policy select encoding presented on the mode input.
  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  // Default geometry of the demultiplexer.
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_NCH    = 4;

  // Next round-robin target: wraps from the last channel back to channel 0.
  function automatic int unsigned rr_wrap_inc(input int unsigned ptr,
                                              input int unsigned nch);
    return (ptr == nch - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_chan_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_chan_reg
//  Description : One-entry holding register for a single output channel.
//                Loads a word on request, drains on valid&ready, and allows
//                drain and load in the same cycle without a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_chan_reg
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // The slot can take a word if it is empty or is being emptied this cycle.
  assign free  = ~r_valid | ready;
  assign valid = r_valid;
  assign data  = r_data;

  // Load wins over drain so a simultaneous drain+load keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux
//  Description : Registered 1-to-NCH stream demultiplexer with valid/ready
//                on the input and every output channel. Target is in_sel, or
//                an internal round-robin pointer when STREAM_DEMUX_RR_EN is
//                defined and mode=MODE_RR. Targets >= NCH are discarded
//                with a one-cycle err pulse.
//  Options     : `define STREAM_DEMUX_RR_EN to build the round-robin path.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NCH    = DEFAULT_NCH,
  parameter int SEL_W  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  mode,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic                  err,
  output logic [SEL_W-1:0]      rr_ptr
);

  localparam logic [SEL_W:0] C_NCH = (SEL_W + 1)'(NCH);

  logic [SEL_W-1:0] w_target;
  logic             w_target_ok;
  logic             w_free_sel;
  logic             w_accept;
  logic [NCH-1:0]   w_free;
  logic [NCH-1:0]   w_load;
  logic             r_err;

`ifdef STREAM_DEMUX_RR_EN
  logic [SEL_W-1:0] r_rr_ptr;
  logic             w_rr_mode;

  assign w_rr_mode = (mode == MODE_RR);
  assign w_target  = w_rr_mode ? r_rr_ptr : in_sel;
  assign rr_ptr    = r_rr_ptr;

  // Pointer moves only when a word is actually taken in round-robin mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept && w_rr_mode) begin
      r_rr_ptr <= SEL_W'(rr_wrap_inc(32'(r_rr_ptr), NCH));
    end
  end
`else
  // Addressed-only build: mode has no effect and the pointer reads as 0.
  logic w_mode_unused;
  assign w_mode_unused = mode;
  assign w_target      = in_sel;
  assign rr_ptr        = '0;
`endif

  // Targets beyond the last channel exist only for non-power-of-2 NCH.
  assign w_target_ok = ({1'b0, w_target} < C_NCH);

  // Pick the free flag of the targeted channel without an out-of-range index.
  always_comb begin
    w_free_sel = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (w_target == SEL_W'(k)) begin
        w_free_sel = w_free[k];
      end
    end
  end

  // Invalid targets are always accepted so they can be dropped.
  assign in_ready = w_target_ok ? w_free_sel : 1'b1;
  assign w_accept = in_valid & in_ready;

  // One-hot load strobe to the targeted channel register.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_accept && w_target_ok && (w_target == SEL_W'(k))) begin
        w_load[k] = 1'b1;
      end
    end
  end

  // Registered one-cycle pulse for each discarded word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_target_ok;
    end
  end

  assign err = r_err;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    demux_chan_reg #(
      .DATA_W(DATA_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load[k]),
      .load_data(in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*DATA_W +: DATA_W]),
      .free     (w_free[k])
    );
  end

endmodule
`default_nettype wire
